// File: rtl/pipe_muldiv_unit_if.sv
// EXE-stage <-> multiply/divide unit bus: request, mthi/mtlo writes and HI/LO readback.
interface pipe_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] wdata;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/pipe_muldiv_unit.sv
// Iterative mult/multu/div/divu unit owning HI/LO: radix-2 shift-add multiply,
// restoring divide on magnitudes, sign fix-up in a final cycle.
module pipe_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    pipe_muldiv_unit_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    state_t              state_r;
    logic [1:0]          op_r;
    logic [XLEN-1:0]     divisor_r;     // multiplicand for mul, divisor for div
    logic [2*XLEN-1:0]   acc_r;         // mul: {partial, multiplier}; div: {rem, quo}
    logic [CNT_W-1:0]    cnt_r;
    logic                sign_q_r;
    logic                sign_r_r;
    logic                dz_r;
    logic [XLEN-1:0]     dz_a_r;
    logic                busy_r;
    logic                done_r;
    logic [XLEN-1:0]     hi_r;
    logic [XLEN-1:0]     lo_r;

    logic                is_signed_s;
    logic [XLEN-1:0]     a_mag_s;
    logic [XLEN-1:0]     b_mag_s;
    logic [XLEN:0]       mul_sum_s;
    logic [XLEN:0]       div_shift_s;
    logic [XLEN:0]       div_diff_s;
    logic [2*XLEN-1:0]   acc_next_s;
    logic [2*XLEN-1:0]   prod_fix_s;
    logic [XLEN-1:0]     quo_fix_s;
    logic [XLEN-1:0]     rem_fix_s;
    logic [XLEN-1:0]     hi_res_s;
    logic [XLEN-1:0]     lo_res_s;

    // Operand magnitudes for the request presented on the bus.
    always_comb begin
        is_signed_s = ~bus.op[0];
        if (is_signed_s && bus.a[XLEN-1]) begin
            a_mag_s = -bus.a;
        end else begin
            a_mag_s = bus.a;
        end
        if (is_signed_s && bus.b[XLEN-1]) begin
            b_mag_s = -bus.b;
        end else begin
            b_mag_s = bus.b;
        end
    end

    // One multiply or divide iteration on the accumulator.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]};
        div_shift_s = acc_r[2*XLEN-1:XLEN-1];
        div_diff_s  = div_shift_s - {1'b0, divisor_r};
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, divisor_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]};
        end
        if (!op_r[1]) begin
            acc_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end else if (!div_diff_s[XLEN]) begin
            acc_next_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
        end else begin
            acc_next_s = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction and final HI/LO selection; divide-by-zero bypasses it.
    always_comb begin
        if (sign_q_r) begin
            prod_fix_s = -acc_r;
            quo_fix_s  = -acc_r[XLEN-1:0];
        end else begin
            prod_fix_s = acc_r;
            quo_fix_s  = acc_r[XLEN-1:0];
        end
        if (sign_r_r) begin
            rem_fix_s = -acc_r[2*XLEN-1:XLEN];
        end else begin
            rem_fix_s = acc_r[2*XLEN-1:XLEN];
        end
        if (dz_r) begin
            hi_res_s = dz_a_r;
            lo_res_s = {XLEN{1'b1}};
        end else if (op_r[1]) begin
            hi_res_s = rem_fix_s;
            lo_res_s = quo_fix_s;
        end else begin
            hi_res_s = prod_fix_s[2*XLEN-1:XLEN];
            lo_res_s = prod_fix_s[XLEN-1:0];
        end
    end

    // Control FSM, datapath registers and HI/LO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            op_r      <= 2'b00;
            divisor_r <= '0;
            acc_r     <= '0;
            cnt_r     <= '0;
            sign_q_r  <= 1'b0;
            sign_r_r  <= 1'b0;
            dz_r      <= 1'b0;
            dz_a_r    <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hi_r      <= '0;
            lo_r      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        op_r      <= bus.op;
                        divisor_r <= b_mag_s;
                        acc_r     <= {{XLEN{1'b0}}, a_mag_s};
                        cnt_r     <= '0;
                        sign_q_r  <= is_signed_s & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                        sign_r_r  <= is_signed_s & bus.a[XLEN-1];
                        dz_r      <= bus.op[1] & (bus.b == {XLEN{1'b0}});
                        dz_a_r    <= bus.a;
                        busy_r    <= 1'b1;
                        state_r   <= ST_RUN;
                    end else begin
                        if (bus.hi_we) begin
                            hi_r <= bus.wdata;
                        end
                        if (bus.lo_we) begin
                            lo_r <= bus.wdata;
                        end
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_W'(XLEN-1)) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_r    <= hi_res_s;
                    lo_r    <= lo_res_s;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule
